// File: rtl/bcd_entry_to_signed.sv
// Decimal-entry front end: accumulates BCD digits into a 12-bit magnitude with a
// pending sign, and commits a 13-bit two's-complement value on enter.
module bcd_entry_to_signed (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  output logic        digit_ready,
  input  logic        neg_toggle,
  input  logic        clear,
  input  logic        enter,
  output logic [12:0] num,
  output logic        num_valid,
  output logic [12:0] entry,
  output logic [2:0]  digit_count,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [11:0]        acc, acc_nx;
  logic               neg, neg_nx;
  logic [2:0]         count, count_nx;
  logic               err_nx;
  logic [12:0]        num_nx;
  logic               num_valid_nx;
  logic [3:0]         digit_p0, digit_p0_nx;
  logic [15:0]        prod_p1, prod_p1_nx;
  logic [16:0]        sum_p2;
  logic               reject_p2;
  logic signed [12:0] entry_s;

  function automatic logic signed [12:0] apply_sign(input logic n, input logic [11:0] mag);
    logic signed [12:0] ext;
    ext = signed'({1'b0, mag});
    return n ? (~ext + 13'sd1) : ext;
  endfunction

  function automatic logic [15:0] times_ten(input logic [11:0] a);
    return ({4'b0, a} << 3) + ({4'b0, a} << 1);
  endfunction

  assign entry_s     = apply_sign(neg, acc);
  assign entry       = entry_s;
  assign digit_count = count;
  assign digit_ready = (state == IDLE);

  // ADD stage: a full register, an overflowing sum or a non-BCD digit all reject
  assign sum_p2    = {1'b0, prod_p1} + {13'b0, digit_p0};
  assign reject_p2 = (count == 3'd4) || (sum_p2 > 17'd4095) || (digit_p0 > 4'd9);

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    neg_nx       = neg;
    count_nx     = count;
    err_nx       = err;
    num_nx       = num;
    num_valid_nx = 1'b0;
    digit_p0_nx  = digit_p0;
    prod_p1_nx   = prod_p1;
    if (clear) begin
      state_nx = IDLE;
      acc_nx   = 12'd0;
      neg_nx   = 1'b0;
      count_nx = 3'd0;
      err_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enter) begin
            num_nx       = apply_sign(neg, acc);
            num_valid_nx = 1'b1;
            acc_nx       = 12'd0;
            neg_nx       = 1'b0;
            count_nx     = 3'd0;
            err_nx       = 1'b0;
          end else if (neg_toggle) begin
            neg_nx = ~neg;
          end else if (digit_valid) begin
            digit_p0_nx = digit_in;
            state_nx    = MUL;
          end
        end
        MUL: begin
          prod_p1_nx = times_ten(acc);
          state_nx   = ADD;
        end
        ADD: begin
          if (reject_p2) begin
            err_nx = 1'b1;
          end else begin
            acc_nx   = sum_p2[11:0];
            count_nx = count + 3'd1;
          end
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= 12'd0;
      neg       <= 1'b0;
      count     <= 3'd0;
      err       <= 1'b0;
      num       <= 13'd0;
      num_valid <= 1'b0;
      digit_p0  <= 4'd0;
      prod_p1   <= 16'd0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      neg       <= neg_nx;
      count     <= count_nx;
      err       <= err_nx;
      num       <= num_nx;
      num_valid <= num_valid_nx;
      digit_p0  <= digit_p0_nx;
      prod_p1   <= prod_p1_nx;
    end
  end

endmodule

// File: tb/tb_bcd_entry_to_signed.sv
// Bench for bcd_entry_to_signed: directed vector table, hand-written corner
// sequences, and random operations checked against an integer reference model.
module tb_bcd_entry_to_signed;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_valid = 1'b0;
  logic        digit_ready;
  logic        neg_toggle = 1'b0;
  logic        clear = 1'b0;
  logic        enter = 1'b0;
  logic [12:0] num;
  logic        num_valid;
  logic [12:0] entry;
  logic [2:0]  digit_count;
  logic        err;

  bcd_entry_to_signed dut (
    .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_ready(digit_ready), .neg_toggle(neg_toggle), .clear(clear), .enter(enter),
    .num(num), .num_valid(num_valid), .entry(entry), .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: plain integers
  int m_acc = 0, m_neg = 0, m_cnt = 0, m_err = 0, m_num = 0;

  localparam int OP_DIG = 0, OP_NEG = 1, OP_CLR = 2, OP_ENT = 3;

  typedef struct {
    int op; int d; int e_entry; int e_cnt; int e_err; int e_num;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] m_signed(input int n, input int mag);
    return n ? ((-mag) & 32'h1FFF) : mag;
  endfunction

  function automatic void add(input int op, input int d, input int e, input int c,
                              input int r, input int nm);
    vec_t v;
    v.op = op; v.d = d; v.e_entry = e; v.e_cnt = c; v.e_err = r; v.e_num = nm;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    m_acc = 0; m_neg = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".entry"}, {19'd0, entry}, m_signed(m_neg, m_acc));
    chk({tag, ".count"}, {29'd0, digit_count}, m_cnt);
    chk({tag, ".err"}, {31'd0, err}, m_err);
    chk({tag, ".num"}, {19'd0, num}, m_num);
    chk({tag, ".ready"}, {31'd0, digit_ready}, 1);
  endtask

  task automatic do_digit(input int d);
    int w;
    logic [12:0] old;
    w = 0;
    while (!digit_ready && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) chk("ready_timeout", 0, 1);
    old = entry;
    digit_in = d[3:0];
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("dig.busy_mul", {31'd0, digit_ready}, 0);
    tick();
    chk("dig.busy_add", {31'd0, digit_ready}, 0);
    chk("dig.entry_hold", {19'd0, entry}, {19'd0, old});
    tick();
    chk("dig.ready_back", {31'd0, digit_ready}, 1);
    if (m_cnt == 4 || m_acc * 10 + d > 4095 || d > 9) m_err = 1;
    else begin
      m_acc = m_acc * 10 + d;
      m_cnt++;
    end
  endtask

  task automatic do_neg();
    neg_toggle = 1'b1;
    tick();
    neg_toggle = 1'b0;
    m_neg = !m_neg;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
  endtask

  task automatic do_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    m_num = m_signed(m_neg, m_acc);
    m_clear();
    chk("ent.pulse", {31'd0, num_valid}, 1);
    chk("ent.num", {19'd0, num}, m_num);
    tick();
    chk("ent.pulse_end", {31'd0, num_valid}, 0);
  endtask

  task automatic apply_op(input int op, input int d);
    case (op)
      OP_DIG: do_digit(d);
      OP_NEG: do_neg();
      OP_CLR: do_clear();
      default: do_enter();
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // directed vectors
    add(OP_DIG, 1, 1, 1, 0, 0);
    add(OP_DIG, 2, 12, 2, 0, 0);
    add(OP_DIG, 3, 123, 3, 0, 0);
    add(OP_ENT, 0, 0, 0, 0, 'h007B);
    add(OP_NEG, 0, 0, 0, 0, 'h007B);
    add(OP_DIG, 4, 'h1FFC, 1, 0, 'h007B);
    add(OP_DIG, 5, 'h1FD3, 2, 0, 'h007B);
    add(OP_ENT, 0, 0, 0, 0, 'h1FD3);
    add(OP_DIG, 4, 4, 1, 0, 'h1FD3);
    add(OP_DIG, 0, 40, 2, 0, 'h1FD3);
    add(OP_DIG, 9, 409, 3, 0, 'h1FD3);
    add(OP_DIG, 5, 4095, 4, 0, 'h1FD3);
    add(OP_DIG, 1, 4095, 4, 1, 'h1FD3);
    add(OP_CLR, 0, 0, 0, 0, 'h1FD3);
    add(OP_DIG, 4, 4, 1, 0, 'h1FD3);
    add(OP_DIG, 0, 40, 2, 0, 'h1FD3);
    add(OP_DIG, 9, 409, 3, 0, 'h1FD3);
    add(OP_DIG, 6, 409, 3, 1, 'h1FD3);
    add(OP_CLR, 0, 0, 0, 0, 'h1FD3);
    add(OP_DIG, 12, 0, 0, 1, 'h1FD3);
    add(OP_CLR, 0, 0, 0, 0, 'h1FD3);
    add(OP_NEG, 0, 0, 0, 0, 'h1FD3);
    add(OP_ENT, 0, 0, 0, 0, 0);

    // reset state
    #1 reset_n = 1'b0;
    #7;
    chk("rst.ready", {31'd0, digit_ready}, 1);
    chk("rst.num", {19'd0, num}, 0);
    chk("rst.num_valid", {31'd0, num_valid}, 0);
    chk("rst.entry", {19'd0, entry}, 0);
    chk("rst.count", {29'd0, digit_count}, 0);
    chk("rst.err", {31'd0, err}, 0);
    #4 reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      apply_op(tbl[i].op, tbl[i].d);
      chk($sformatf("vec%0d.entry", i), {19'd0, entry}, tbl[i].e_entry);
      chk($sformatf("vec%0d.count", i), {29'd0, digit_count}, tbl[i].e_cnt);
      chk($sformatf("vec%0d.err", i), {31'd0, err}, tbl[i].e_err);
      chk($sformatf("vec%0d.num", i), {19'd0, num}, tbl[i].e_num);
    end

    // digit_valid held high: one accept every third cycle
    digit_in = 4'd7;
    digit_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("hold.ready%0d", i), {31'd0, digit_ready}, (i % 3 == 0) ? 1 : 0);
      chk($sformatf("hold.entry%0d", i), {19'd0, entry}, (i < 3) ? 0 : (i < 6) ? 7 : 77);
      tick();
    end
    chk("hold.ready9", {31'd0, digit_ready}, 1);
    chk("hold.entry9", {19'd0, entry}, 777);
    digit_valid = 1'b0;
    m_acc = 777; m_cnt = 3;
    check_model("hold");
    do_clear();

    // clear during ADD discards the in-flight digit
    do_digit(4);
    digit_in = 4'd8;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    check_model("clr_add");
    tick();
    tick();
    check_model("clr_add_late");

    // neg_toggle beats a digit in the same cycle
    neg_toggle = 1'b1;
    digit_in = 4'd2;
    digit_valid = 1'b1;
    tick();
    neg_toggle = 1'b0;
    digit_valid = 1'b0;
    m_neg = 1;
    check_model("neg_vs_dig");
    do_digit(2);
    check_model("neg_vs_dig2");
    do_clear();

    // enter beats neg_toggle in the same cycle
    do_digit(7);
    enter = 1'b1;
    neg_toggle = 1'b1;
    tick();
    enter = 1'b0;
    neg_toggle = 1'b0;
    chk("ent_vs_neg.pulse", {31'd0, num_valid}, 1);
    chk("ent_vs_neg.num", {19'd0, num}, 7);
    m_num = 7;
    m_clear();
    do_digit(3);
    check_model("ent_vs_neg");

    // clear beats enter: no commit
    do_digit(5);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    m_clear();
    chk("clr_vs_ent.pulse", {31'd0, num_valid}, 0);
    check_model("clr_vs_ent");
    tick();
    chk("clr_vs_ent.pulse2", {31'd0, num_valid}, 0);

    // asynchronous reset in the middle of MUL
    do_digit(2);
    do_enter();
    do_digit(5);
    digit_in = 4'd6;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("rst_mul.busy", {31'd0, digit_ready}, 0);
    reset_n = 1'b0;
    #2;
    m_clear();
    m_num = 0;
    chk("rst_mul.num_valid", {31'd0, num_valid}, 0);
    check_model("rst_mul");
    #2 reset_n = 1'b1;
    tick();
    tick();
    check_model("rst_mul_after");

    // random operations against the model
    for (int i = 0; i < 400; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if (r < 6 || r == 9) apply_op(OP_DIG, d);
      else if (r == 6) apply_op(OP_NEG, 0);
      else if (r == 7) apply_op(OP_CLR, 0);
      else apply_op(OP_ENT, 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
